smvm_stream_tx: RTL and testbench

SMVM_STREAM_TX -- requirements
Module: smvm_stream_tx

---
 rtl/smvm_pkg.sv | 15 +
 rtl/smvm_nz_packer.sv | 62 ++++++
 rtl/smvm_stream_tx.sv | 141 ++++++++++++++
 tb/tb_smvm_stream_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smvm_pkg.sv
// rtl/smvm_pkg.sv - shared state encoding and stream widths for the sparse matrix stream transmitter
package smvm_pkg;
  localparam int unsigned VAL_W        = 8;
  localparam int unsigned COL_W        = 8;
  localparam int unsigned DEF_MAX_COLS = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_VEC,
    ST_MAT,
    ST_FLUSH,
    ST_TERM
  } smvm_state_e;
endpackage

// File: rtl/smvm_nz_packer.sv
// rtl/smvm_nz_packer.sv - one-entry pending register, row-end (ipv) decision and empty-row detection
module smvm_nz_packer
  import smvm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             beat,
  input  logic [VAL_W-1:0] beat_val,
  input  logic [COL_W-1:0] beat_col,
  input  logic [7:0]       beat_row,
  input  logic             row_end,
  input  logic             flush,
  output logic             emit,
  output logic [VAL_W-1:0] emit_val,
  output logic [COL_W-1:0] emit_col,
  output logic             emit_ipv,
  output logic             err_empty_row
);
  logic             pend_valid;
  logic [VAL_W-1:0] pend_val;
  logic [COL_W-1:0] pend_col;
  logic [7:0]       pend_row;
  logic             row_nz;
  logic             nz;

  assign nz       = beat_val != '0;
  assign emit     = pend_valid && ((beat && nz) || flush);
  assign emit_val = pend_val;
  assign emit_col = pend_col;
  // A pending entry is the last of its row exactly when the next nonzero lands on a later row.
  assign emit_ipv = flush || (pend_row < beat_row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid    <= 1'b0;
      pend_val      <= '0;
      pend_col      <= '0;
      pend_row      <= '0;
      row_nz        <= 1'b0;
      err_empty_row <= 1'b0;
    end else if (clear) begin
      pend_valid    <= 1'b0;
      row_nz        <= 1'b0;
      err_empty_row <= 1'b0;
    end else begin
      if (beat) begin
        if (nz) begin
          pend_valid <= 1'b1;
          pend_val   <= beat_val;
          pend_col   <= beat_col;
          pend_row   <= beat_row;
        end
        row_nz <= row_end ? 1'b0 : (row_nz || nz);
        if (row_end && !(row_nz || nz))
          err_empty_row <= 1'b1;
      end
      if (flush)
        pend_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/smvm_stream_tx.sv
// rtl/smvm_stream_tx.sv - job FSM and counters turning a dense vector+matrix load into a sparse entry stream
module smvm_stream_tx
  import smvm_pkg::*;
#(
  parameter int unsigned MAX_COLS = DEF_MAX_COLS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       cfg_rows,
  input  logic [7:0]       cfg_cols,
  input  logic             ld_valid,
  input  logic [VAL_W-1:0] ld_data,
  output logic             ld_ready,
  output logic [VAL_W-1:0] val_out,
  output logic [COL_W-1:0] col_out,
  output logic             ipv_out,
  output logic             busy,
  output logic             done,
  output logic             err_empty_row
);
  smvm_state_e      state, state_nxt;
  logic [7:0]       rows_q, cols_q, row_cnt, col_cnt;
  logic [VAL_W-1:0] val_nxt;
  logic [COL_W-1:0] col_nxt;
  logic             ipv_nxt, done_nxt;
  logic             start_ok, job_start, accept, col_last, row_last, mat_beat, flush;
  logic             pk_emit, pk_ipv;
  logic [VAL_W-1:0] pk_val;
  logic [COL_W-1:0] pk_col;

  assign start_ok  = start && (cfg_rows != 8'd0) && (cfg_cols != 8'd0) && (32'(cfg_cols) <= MAX_COLS);
  assign job_start = (state == ST_IDLE) && start_ok;
  assign ld_ready  = (state == ST_VEC) || (state == ST_MAT);
  assign accept    = ld_valid && ld_ready;
  assign col_last  = col_cnt == cols_q - 8'd1;
  assign row_last  = row_cnt == rows_q - 8'd1;
  assign mat_beat  = accept && (state == ST_MAT);
  assign flush     = state == ST_FLUSH;
  assign busy      = state != ST_IDLE;

  smvm_nz_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (job_start),
    .beat         (mat_beat),
    .beat_val     (ld_data),
    .beat_col     (col_cnt),
    .beat_row     (row_cnt),
    .row_end      (col_last),
    .flush        (flush),
    .emit         (pk_emit),
    .emit_val     (pk_val),
    .emit_col     (pk_col),
    .emit_ipv     (pk_ipv),
    .err_empty_row(err_empty_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    val_nxt   = '0;
    col_nxt   = '0;
    ipv_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_HDR;
          val_nxt   = cfg_rows;
          col_nxt   = cfg_cols;
        end
      end
      ST_HDR: state_nxt = ST_VEC;
      ST_VEC: begin
        col_nxt = col_cnt;
        if (accept) begin
          val_nxt = ld_data;
          if (col_last) state_nxt = ST_MAT;
        end
      end
      ST_MAT: begin
        if (pk_emit) begin
          val_nxt = pk_val;
          col_nxt = pk_col;
          ipv_nxt = pk_ipv;
        end
        if (accept && col_last && row_last) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (pk_emit) begin
          val_nxt = pk_val;
          col_nxt = pk_col;
          ipv_nxt = pk_ipv;
        end
        state_nxt = ST_TERM;
      end
      ST_TERM: begin
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counters wrap at the configured limits only; the column counter doubles as the vector index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q  <= '0;
      cols_q  <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      val_out <= '0;
      col_out <= '0;
      ipv_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (job_start) begin
        rows_q  <= cfg_rows;
        cols_q  <= cfg_cols;
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_cnt <= '0;
          if (state == ST_MAT) row_cnt <= row_last ? 8'd0 : row_cnt + 8'd1;
        end else begin
          col_cnt <= col_cnt + 8'd1;
        end
      end
      val_out <= val_nxt;
      col_out <= col_nxt;
      ipv_out <= ipv_nxt;
      done    <= done_nxt;
    end
  end
endmodule

// File: tb/tb_smvm_stream_tx.sv
// tb/tb_smvm_stream_tx.sv - self-checking bench for smvm_stream_tx against a row-level sparse model
module tb_smvm_stream_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_rows = '0;
  logic [7:0] cfg_cols = '0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_ready, ipv_out, busy, done, err_empty_row;
  logic [7:0] val_out, col_out;

  int checks = 0;
  int fails  = 0;
  logic [7:0] vec_q[$];
  logic [7:0] mat_q[$];

  always #5 clk = ~clk;

  smvm_stream_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .val_out(val_out),
    .col_out(col_out), .ipv_out(ipv_out), .busy(busy), .done(done), .err_empty_row(err_empty_row)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int rows, input int cols);
    vec_q.delete();
    mat_q.delete();
    for (int i = 0; i < cols; i++) vec_q.push_back(8'($urandom_range(255)));
    for (int i = 0; i < rows * cols; i++)
      mat_q.push_back(($urandom_range(1) == 1) ? 8'd0 : 8'($urandom_range(255, 1)));
  endtask

  // Drives one full job from the queues; expected entries come from "nonzeros in row-major order,
  // ipv on the last nonzero of each row".
  task automatic run_job(input int rows, input int cols, input int gap_pct);
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int lc, idx, r, c;
    bit exp_err, empty;
    exp_err = 1'b0;
    for (int rr = 0; rr < rows; rr++) begin
      lc = -1;
      for (int cc = 0; cc < cols; cc++) if (mat_q[rr*cols+cc] != 8'd0) lc = cc;
      for (int cc = 0; cc < cols; cc++)
        if (mat_q[rr*cols+cc] != 8'd0) exp_q.push_back({mat_q[rr*cols+cc], 8'(cc), cc == lc});
    end

    start = 1'b1; cfg_rows = 8'(rows); cfg_cols = 8'(cols); ld_valid = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if ({val_out, col_out, ipv_out, busy, ld_ready, err_empty_row} !== {8'(rows), 8'(cols), 4'b0100}) begin
      fails++;
      $display("FAIL header got val=%0d col=%0d ipv=%0b busy=%0b rdy=%0b err=%0b exp val=%0d col=%0d ipv=0 busy=1 rdy=0 err=0",
               val_out, col_out, ipv_out, busy, ld_ready, err_empty_row, rows, cols);
    end

    ld_valid = 1'b1; ld_data = vec_q[0];
    step();
    checks++;
    if (val_out !== 8'd0) begin
      fails++;
      $display("FAIL hdr_beat_not_consumed got val=%0d exp 0", val_out);
    end

    idx = 0;
    while (idx < cols) begin
      if ($urandom_range(99) < gap_pct) begin
        ld_valid = 1'b0;
        step();
        checks++;
        if (val_out !== 8'd0) begin
          fails++;
          $display("FAIL vec_gap got val=%0d exp 0", val_out);
        end
      end else begin
        checks++;
        if (ld_ready !== 1'b1) begin
          fails++;
          $display("FAIL vec_ready got %0b exp 1", ld_ready);
        end
        ld_valid = 1'b1; ld_data = vec_q[idx];
        step();
        checks++;
        if ({val_out, col_out, ipv_out} !== {vec_q[idx], 8'(idx), 1'b0}) begin
          fails++;
          $display("FAIL vec_beat got (%0h,%0d,%0b) exp (%0h,%0d,0)", val_out, col_out, ipv_out, vec_q[idx], idx);
        end
        idx++;
      end
    end

    r = 0; c = 0;
    while (r < rows) begin
      if ($urandom_range(99) < gap_pct) begin
        ld_valid = 1'b0;
        step();
        checks++;
        if ({val_out, col_out, ipv_out} !== 17'd0) begin
          fails++;
          $display("FAIL mat_gap got (%0h,%0d,%0b) exp (0,0,0)", val_out, col_out, ipv_out);
        end
      end else begin
        ld_valid = 1'b1; ld_data = mat_q[r*cols+c];
        step();
        if (val_out != 8'd0) got_q.push_back({val_out, col_out, ipv_out});
        if (c == cols - 1) begin
          empty = 1'b1;
          for (int cc = 0; cc < cols; cc++) if (mat_q[r*cols+cc] != 8'd0) empty = 1'b0;
          exp_err = exp_err | empty;
          checks++;
          if (err_empty_row !== exp_err) begin
            fails++;
            $display("FAIL err_after_row%0d got %0b exp %0b", r, err_empty_row, exp_err);
          end
          c = 0;
          r++;
        end else begin
          c++;
        end
      end
    end
    ld_valid = 1'b0;

    checks++;
    if ({ld_ready, busy} !== 2'b01) begin
      fails++;
      $display("FAIL flush_state got rdy=%0b busy=%0b exp rdy=0 busy=1", ld_ready, busy);
    end
    step();
    if (val_out != 8'd0) got_q.push_back({val_out, col_out, ipv_out});
    checks++;
    if ({busy, done} !== 2'b10) begin
      fails++;
      $display("FAIL term_state got busy=%0b done=%0b exp busy=1 done=0", busy, done);
    end
    step();
    checks++;
    if ({val_out, col_out, ipv_out, done, busy} !== {17'd0, 2'b10}) begin
      fails++;
      $display("FAIL terminator got (%0h,%0d,%0b) done=%0b busy=%0b exp (0,0,0) done=1 busy=0",
               val_out, col_out, ipv_out, done, busy);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse_width got %0b exp 0", done);
    end

    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL entry_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL entry%0d got (%0h,%0d,%0b) exp (%0h,%0d,%0b)", i, got_q[i][16:9], got_q[i][8:1],
                 got_q[i][0], exp_q[i][16:9], exp_q[i][8:1], exp_q[i][0]);
      end
    end
    checks++;
    if (err_empty_row !== exp_err) begin
      fails++;
      $display("FAIL err_final got %0b exp %0b", err_empty_row, exp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({val_out, col_out, ipv_out, ld_ready, busy, done, err_empty_row} !== 21'd0) begin
      fails++;
      $display("FAIL reset_state got val=%0d col=%0d ipv=%0b rdy=%0b busy=%0b done=%0b err=%0b exp all 0",
               val_out, col_out, ipv_out, ld_ready, busy, done, err_empty_row);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_job();
    vec_q = '{8'd5, 8'd0, 8'hFF};
    mat_q = '{8'd4, 8'd0, 8'd7, 8'd0, 8'd0, 8'hFE};
    run_job(2, 3, 0);
  endtask

  task automatic test_empty_row();
    vec_q = '{8'd1, 8'd2};
    mat_q = '{8'd3, 8'd5, 8'd0, 8'd0, 8'hFC, 8'd0};
    run_job(3, 2, 0);
    vec_q = '{8'd9};
    mat_q = '{8'd6};
    run_job(1, 1, 0);
  endtask

  task automatic test_gaps_illegal();
    int bad_r[3] = '{2, 2, 0};
    int bad_c[3] = '{0, 129, 3};
    vec_q = '{8'd1, 8'd2, 8'd3};
    mat_q = '{8'd0, 8'd8, 8'd0, 8'd1, 8'd0, 8'd2};
    run_job(2, 3, 40);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; cfg_rows = 8'(bad_r[i]); cfg_cols = 8'(bad_c[i]);
      step();
      start = 1'b0;
      step();
      checks++;
      if ({busy, ld_ready, val_out, col_out} !== 18'd0) begin
        fails++;
        $display("FAIL illegal_start%0d got busy=%0b rdy=%0b val=%0d col=%0d exp all 0",
                 i, busy, ld_ready, val_out, col_out);
      end
    end
  endtask

  task automatic test_random();
    int rows, cols;
    for (int j = 0; j < 6; j++) begin
      rows = $urandom_range(4, 1);
      cols = $urandom_range(6, 1);
      fill_random(rows, cols);
      run_job(rows, cols, 30);
    end
    fill_random(2, 128);
    run_job(2, 128, 10);
  endtask

  task automatic test_reset_mid_job();
    start = 1'b1; cfg_rows = 8'd3; cfg_cols = 8'd2;
    step();
    start = 1'b0; ld_valid = 1'b0;
    step();
    ld_valid = 1'b1; ld_data = 8'd1;
    step();
    ld_data = 8'd2;
    step();
    ld_data = 8'd7;
    step();
    ld_data = 8'd9;
    step();
    checks++;
    if ({val_out, col_out, ipv_out} !== {8'd7, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL pre_reset_emit got (%0h,%0d,%0b) exp (7,0,0)", val_out, col_out, ipv_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({val_out, col_out, ipv_out, ld_ready, busy, done} !== 20'd0) begin
      fails++;
      $display("FAIL async_reset got val=%0d col=%0d ipv=%0b rdy=%0b busy=%0b done=%0b exp all 0",
               val_out, col_out, ipv_out, ld_ready, busy, done);
    end
    ld_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    vec_q = '{8'd3, 8'd4};
    mat_q = '{8'd0, 8'd5};
    run_job(1, 2, 0);
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_empty_row();
    test_gaps_illegal();
    test_random();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
